// File: rtl/protocore_pkg.sv
// Shared types and defaults for the load/store memory unit.
// The store-buffer entry is sized by the package defaults.
package protocore_pkg;

  localparam int unsigned DMU_ADDR_W = 8;
  localparam int unsigned DMU_DATA_W = 8;

  typedef enum logic [0:0] {
    DMU_IDLE,
    DMU_LOAD_RSP
  } dmu_state_e;

  typedef struct packed {
    logic [DMU_ADDR_W-1:0] addr;
    logic [DMU_DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port synchronous RAM. Read data is registered and held until the next read.
// No reset: contents and the read register power up undefined.
module dmem_ram #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/data_mem_unit.sv
// Load/store responder: posted stores go through a FIFO store buffer that drains into a
// single-port RAM; loads forward from the youngest matching buffer entry or read the RAM.
module data_mem_unit
  import protocore_pkg::*;
#(
  parameter int unsigned ADDR_W   = DMU_ADDR_W,
  parameter int unsigned DATA_W   = DMU_DATA_W,
  parameter int unsigned SB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_idle
);

  localparam int unsigned PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(SB_DEPTH) + 1;

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input int unsigned k);
    int unsigned s;
    s = (32'(p) + k) % SB_DEPTH;
    return PTR_W'(s);
  endfunction

  dmu_state_e        state_q, state_d;
  sb_entry_t         sb_q [SB_DEPTH];
  logic [PTR_W-1:0]  head_q, tail_q;
  logic [CNT_W-1:0]  count_q;
  logic              sb_full, sb_empty;
  logic              accept, push, load_acc, drain;
  logic              fwd_hit, fwd_hit_q;
  logic [DATA_W-1:0] fwd_data, fwd_data_q;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign sb_full  = (count_q == CNT_W'(SB_DEPTH));
  assign sb_empty = (count_q == '0);

  // Gated by rst_n so nothing reaches the (unreset) RAM while reset is asserted.
  assign accept   = rst_n & req_valid & req_ready;
  assign push     = accept & req_we;
  assign load_acc = accept & ~req_we;
  assign drain    = rst_n & ~accept & ~sb_empty;

  // Walk from oldest to youngest so the youngest match overrides.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if ((i < 32'(count_q)) && (sb_q[ptr_add(head_q, i)].addr == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = sb_q[ptr_add(head_q, i)].data;
      end
    end
  end

  // An accepted request owns the RAM port; the drain only uses otherwise idle cycles.
  assign ram_en    = (load_acc & ~fwd_hit) | drain;
  assign ram_we    = drain;
  assign ram_addr  = drain ? sb_q[head_q].addr : req_addr;
  assign ram_wdata = sb_q[head_q].data;

  dmem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .en   (ram_en),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DMU_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DMU_IDLE:     if (load_acc) state_d = DMU_LOAD_RSP;
      DMU_LOAD_RSP: state_d = DMU_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = (state_q == DMU_IDLE) && !sb_full;
    rsp_valid = (state_q == DMU_LOAD_RSP);
    rsp_rdata = '0;
    if (rsp_valid) begin
      rsp_rdata = fwd_hit_q ? fwd_data_q : ram_rdata;
    end
    mem_idle  = sb_empty && (state_q == DMU_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      if (push) begin
        tail_q <= ptr_add(tail_q, 1);
      end
      if (drain) begin
        head_q <= ptr_add(head_q, 1);
      end
      unique case ({push, drain})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (load_acc) begin
        fwd_hit_q  <= fwd_hit;
        fwd_data_q <= fwd_data;
      end
    end
  end

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      sb_q[tail_q] <= '{addr: req_addr, data: req_wdata};
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && sb_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(drain && sb_empty));

endmodule
